// File: rtl/approx_add_sched_if.sv
// Requester-side bundle of the shared approximate FP32 adder scheduler:
// request/operand lanes in, grant and tagged result out.
interface approx_add_sched_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*32-1:0] op_a;
  logic [NUM_REQ*32-1:0] op_b;
  logic [NUM_REQ-1:0]    gnt;
  logic                  busy;
  logic                  res_valid;
  logic [ID_W-1:0]       res_id;
  logic [31:0]           res;

  modport master (
    output req, op_a, op_b,
    input  gnt, busy, res_valid, res_id, res
  );

  modport slave (
    input  req, op_a, op_b,
    output gnt, busy, res_valid, res_id, res
  );
endinterface

// File: rtl/approx_add_sched.sv
// Round-robin scheduler sharing one multi-cycle truncating FP32 adder
// (ALIGN/ADD/NORM sequencing) among NUM_REQ requesters; results tagged by index.
module approx_add_sched #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst,
  approx_add_sched_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_DONE
  } state_e;

  state_e              state_q;
  logic [ID_W-1:0]     ptr_q;
  logic [ID_W-1:0]     id_q;
  logic [31:0]         a_q;
  logic [31:0]         b_q;
  logic                sign_q;
  logic [7:0]          exp_q;
  logic [24:0]         mant_q;
  logic [23:0]         big_q;
  logic [23:0]         sml_q;
  logic                sub_q;
  logic [NUM_REQ-1:0]  gnt_q;
  logic                busy_q;
  logic                valid_q;
  logic [ID_W-1:0]     res_id_q;
  logic [31:0]         res_q;

  // Operand lanes unpacked so the winner can index them directly.
  logic [31:0] opa_arr [NUM_REQ];
  logic [31:0] opb_arr [NUM_REQ];

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      opa_arr[i] = bus.op_a[32*i +: 32];
      opb_arr[i] = bus.op_b[32*i +: 32];
    end
  end

  logic            found_d;
  logic [ID_W-1:0] win_d;
  logic [ID_W-1:0] idx_d;

  always_comb begin
    found_d = 1'b0;
    win_d   = '0;
    idx_d   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx_d = ID_W'((32'(ptr_q) + k) % NUM_REQ);
      if (!found_d && bus.req[idx_d]) begin
        found_d = 1'b1;
        win_d   = idx_d;
      end
    end
  end

  logic [7:0]  ea_d, eb_d, ediff_d;
  logic [23:0] ma_d, mb_d, msml_d, sml_sh_d;
  logic        a_zero_d, b_zero_d, a_big_d;

  always_comb begin
    ea_d     = a_q[30:23];
    eb_d     = b_q[30:23];
    ma_d     = {1'b1, a_q[22:0]};
    mb_d     = {1'b1, b_q[22:0]};
    a_zero_d = (ea_d == 8'd0);
    b_zero_d = (eb_d == 8'd0);
    a_big_d  = (ea_d > eb_d) || ((ea_d == eb_d) && (ma_d >= mb_d));
    msml_d   = a_big_d ? mb_d : ma_d;
    ediff_d  = a_big_d ? (ea_d - eb_d) : (eb_d - ea_d);
    sml_sh_d = (ediff_d >= 8'd24) ? '0 : (msml_d >> ediff_d);
  end

  logic [24:0] sum_d;
  logic        norm_done_d;
  logic [31:0] norm_res_d;

  always_comb begin
    sum_d = sub_q ? ({1'b0, big_q} - {1'b0, sml_q})
                  : ({1'b0, big_q} + {1'b0, sml_q});
    norm_done_d = 1'b1;
    norm_res_d  = '0;
    if (mant_q[24]) begin
      norm_res_d = (exp_q == 8'hFE) ? {sign_q, 8'hFF, 23'd0}
                                    : {sign_q, exp_q + 8'd1, mant_q[23:1]};
    end else if (mant_q[23]) begin
      norm_res_d = {sign_q, exp_q, mant_q[22:0]};
    end else if (exp_q != 8'd1) begin
      norm_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mant_q   <= '0;
      big_q    <= '0;
      sml_q    <= '0;
      sub_q    <= 1'b0;
      gnt_q    <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      res_id_q <= '0;
      res_q    <= '0;
    end else begin
      gnt_q   <= '0;
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (found_d) begin
            a_q     <= opa_arr[win_d];
            b_q     <= opb_arr[win_d];
            id_q    <= win_d;
            gnt_q   <= NUM_REQ'(1) << win_d;
            busy_q  <= 1'b1;
            ptr_q   <= (32'(win_d) == NUM_REQ - 1) ? '0 : win_d + ID_W'(1);
            state_q <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          if (a_zero_d || b_zero_d) begin
            res_q    <= (a_zero_d && b_zero_d) ? '0 : (a_zero_d ? b_q : a_q);
            res_id_q <= id_q;
            valid_q  <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            sign_q  <= a_big_d ? a_q[31] : b_q[31];
            exp_q   <= a_big_d ? ea_d : eb_d;
            big_q   <= a_big_d ? ma_d : mb_d;
            sml_q   <= sml_sh_d;
            sub_q   <= a_q[31] ^ b_q[31];
            state_q <= S_ADD;
          end
        end
        S_ADD: begin
          if (sum_d == '0) begin
            res_q    <= '0;
            res_id_q <= id_q;
            valid_q  <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            mant_q  <= sum_d;
            state_q <= S_NORM;
          end
        end
        S_NORM: begin
          // Left shifts take one cycle each; an exponent underflow flushes to +0.
          if (norm_done_d) begin
            res_q    <= norm_res_d;
            res_id_q <= id_q;
            valid_q  <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            mant_q <= mant_q << 1;
            exp_q  <= exp_q - 8'd1;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.busy      = busy_q;
  assign bus.res_valid = valid_q;
  assign bus.res_id    = res_id_q;
  assign bus.res       = res_q;

endmodule
